// File: rtl/fmc_i2c_pkg.sv
// Shared definitions for the FMC424 I2C controller and its CPLD stand-in target.
package fmc_i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    WAIT_STOP
  } i2c_state_e;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  localparam logic [6:0] CPLD_ADDR   = 7'h3E;
  localparam logic [6:0] SI5338B_ADR = 7'h70;
  localparam logic [6:0] QSFP_MOD    = 7'h50;

endpackage

// File: rtl/i2c_bus_cond.sv
// I2C bus conditioning: 2-FF synchroniser, optional 3-sample majority filter
// (I2C_TARGET_GLITCH_FILT_EN), then a current/previous stage that yields
// SCL edge and START/STOP flags. Flags are combinational from the last two
// stages: 3 clocks after a pin change, or 5 clocks with the filter.
module i2c_bus_cond (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [1:0] scl_sync, sda_sync;
  logic       scl_cond, sda_cond;
  logic       scl_q, scl_p, sda_q, sda_p;

  // Two-flop synchroniser; idle bus level is high so reset to 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILT_EN
  logic [2:0] scl_win, sda_win;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // Three-sample window; a level needs two samples to win the vote.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_win <= 3'b111;
      sda_win <= 3'b111;
    end else begin
      scl_win <= {scl_win[1:0], scl_sync[1]};
      sda_win <= {sda_win[1:0], sda_sync[1]};
    end
  end

  assign scl_cond = maj3(scl_win);
  assign sda_cond = maj3(sda_win);
`else
  assign scl_cond = scl_sync[1];
  assign sda_cond = sda_sync[1];
`endif

  // Current and previous conditioned levels for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_q <= 1'b1;
      scl_p <= 1'b1;
      sda_q <= 1'b1;
      sda_p <= 1'b1;
    end else begin
      scl_q <= scl_cond;
      scl_p <= scl_q;
      sda_q <= sda_cond;
      sda_p <= sda_q;
    end
  end

  assign sda      = sda_q;
  assign scl_rise = scl_q & ~scl_p;
  assign scl_fall = ~scl_q & scl_p;
  assign start    = scl_q & scl_p & sda_p & ~sda_q;
  assign stop     = scl_q & scl_p & ~sda_p & sda_q;

endmodule

// File: rtl/fmc_i2c_target.sv
// I2C target answering the FMC424 controller, backed by a byte register bank
// with an auto-incrementing pointer. Never stretches SCL.
// Optional feature macro: I2C_TARGET_GLITCH_FILT_EN (majority filter in i2c_bus_cond).
// Handshake: none on the register side; wr_pulse is a one-cycle strobe and
// wr_addr/wr_data are valid in that cycle and held until the next commit.
// SDA drive changes take effect HOLD_CYC clocks after the SCL-fall flag
// asserts (HOLD_CYC must be at least 2).
module fmc_i2c_target
  import fmc_i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = CPLD_ADDR,
  parameter int         NREGS       = 16,
  parameter int         HOLD_CYC    = 4
) (
  input  logic                     CLK,
  input  logic                     rst_n,
  input  logic                     scl_in,
  input  logic                     sda_in,
  output logic                     scl_t,
  output logic                     scl_out,
  output logic                     sda_t,
  output logic                     sda_out,
  output logic [NREGS*8-1:0]       regs_flat,
  output logic                     wr_pulse,
  output logic [$clog2(NREGS)-1:0] wr_addr,
  output logic [7:0]               wr_data,
  output logic                     busy
);

  localparam int AW = $clog2(NREGS);
  localparam int HW = $clog2(HOLD_CYC);

  i2c_state_e    state, state_nxt;
  logic          sda, scl_rise, scl_fall, start, stop;
  logic [3:0]    bit_cnt;
  logic [6:0]    sh;
  logic [7:0]    rx_byte, rbyte;
  logic [AW-1:0] ptr;
  logic [AW+2:0] ptr_bit;
  logic [HW-1:0] hold_cnt;
  logic          last_bit, drive_low;

  i2c_bus_cond u_bus_cond (
    .clk      (CLK),
    .rst_n    (rst_n),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  assign scl_t    = 1'b1;
  assign scl_out  = 1'b0;
  assign sda_out  = 1'b0;
  assign busy     = (state != IDLE);
  assign rx_byte  = {sh, sda};
  assign last_bit = (bit_cnt == 4'd7);
  assign ptr_bit  = {ptr, 3'b000};

  // State register.
  always_ff @(posedge CLK) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: bus conditions win over bit events; ACK phases end on the 9th fall.
  always_comb begin
    state_nxt = state;
    if (stop) begin
      state_nxt = IDLE;
    end else if (start) begin
      state_nxt = ADDR;
    end else if (scl_rise) begin
      case (state)
        ADDR:      if (last_bit) state_nxt = (rx_byte[7:1] == TARGET_ADDR) ? ADDR_ACK : WAIT_STOP;
        PTR:       if (last_bit) state_nxt = PTR_ACK;
        WDATA:     if (last_bit) state_nxt = WDATA_ACK;
        RDATA:     if (last_bit) state_nxt = RDATA_ACK;
        RDATA_ACK: if (sda)      state_nxt = WAIT_STOP;
        default:   state_nxt = state;
      endcase
    end else if (scl_fall && bit_cnt == 4'd9) begin
      case (state)
        ADDR_ACK:           state_nxt = (sh[0] == RW_READ) ? RDATA : PTR;
        PTR_ACK, WDATA_ACK: state_nxt = WDATA;
        RDATA_ACK:          state_nxt = RDATA;
        default:            state_nxt = state;
      endcase
    end
  end

  // SDA level wanted for the current bit period once the hold time expires.
  always_comb begin
    drive_low = 1'b0;
    case (state)
      ADDR_ACK, PTR_ACK, WDATA_ACK: drive_low = (bit_cnt == 4'd9);
      RDATA:   drive_low = !bit_cnt[3] && !rbyte[3'd7 - bit_cnt[2:0]];
      default: drive_low = 1'b0;
    endcase
  end

  // Bit counter, shifter, pointer, register bank, write strobe and SDA drive.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      sh        <= '0;
      rbyte     <= '0;
      ptr       <= '0;
      regs_flat <= '0;
      wr_pulse  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      hold_cnt  <= '0;
      sda_t     <= 1'b1;
    end else begin
      wr_pulse <= 1'b0;
      if (stop || start) begin
        // A partial byte is dropped; pointer and bank stay as they were.
        bit_cnt  <= '0;
        hold_cnt <= '0;
        sda_t    <= 1'b1;
      end else begin
        if (scl_rise) begin
          case (state)
            ADDR, PTR, WDATA: begin
              sh      <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 4'd1;
            end
            RDATA:     bit_cnt <= bit_cnt + 4'd1;
            RDATA_ACK: if (!sda) bit_cnt <= 4'd9;
            default:   ;
          endcase
          if (last_bit) begin
            case (state)
              PTR: ptr <= rx_byte[AW-1:0];
              WDATA: begin
                regs_flat[ptr_bit +: 8] <= rx_byte;
                wr_pulse <= 1'b1;
                wr_addr  <= ptr;
                wr_data  <= rx_byte;
                ptr      <= ptr + 1'b1;
              end
              RDATA:   ptr <= ptr + 1'b1;
              default: ;
            endcase
          end
        end
        if (scl_fall) begin
          hold_cnt <= HW'(HOLD_CYC - 1);
          if (state_nxt != state)
            bit_cnt <= '0;
          else if (bit_cnt == 4'd8 && state inside {ADDR_ACK, PTR_ACK, WDATA_ACK})
            bit_cnt <= 4'd9;
          if (state_nxt == RDATA)
            rbyte <= regs_flat[ptr_bit +: 8];
        end else if (hold_cnt != '0) begin
          hold_cnt <= hold_cnt - 1'b1;
          if (hold_cnt == HW'(1))
            sda_t <= ~drive_low;
        end
      end
    end
  end

endmodule

// File: tb/tb_fmc_i2c_target.sv
// Bench for fmc_i2c_target: open-drain bus model, byte-level controller tasks,
// write-commit scoreboard and SDA hold-time monitor.
module tb_fmc_i2c_target;

  localparam int NREGS    = 16;
  localparam int HOLD_CYC = 4;
  localparam int Q        = 10;
`ifdef I2C_TARGET_GLITCH_FILT_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ctrl_scl = 1'b1;
  logic ctrl_sda = 1'b1;
  logic scl_in, sda_in, scl_t, scl_out, sda_t, sda_out, wr_pulse, busy;
  logic [NREGS*8-1:0] regs_flat;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  assign scl_in = ctrl_scl & (scl_t | scl_out);
  assign sda_in = ctrl_sda & (sda_t | sda_out);

  fmc_i2c_target dut (
    .CLK       (clk),
    .rst_n     (rst_n),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_t     (scl_t),
    .scl_out   (scl_out),
    .sda_t     (sda_t),
    .sda_out   (sda_out),
    .regs_flat (regs_flat),
    .wr_pulse  (wr_pulse),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  logic [11:0] exp_q[$];
  logic [7:0]  model [NREGS];
  int n_tests = 0;
  int n_fail = 0;
  int fall_cyc = 0;
  int low_cnt = 0;
  bit chk_en = 1'b0;
  bit glitch_win = 1'b0;
  bit glitch_seen = 1'b0;
  logic prev_sda_t = 1'b1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NREGS*8-1:0] model_flat();
    logic [NREGS*8-1:0] f;
    for (int i = 0; i < NREGS; i++) f[i*8 +: 8] = model[i];
    return f;
  endfunction

  // Monitor: SDA hold timing, low-drive count, write commits, glitch window
  always @(posedge clk) begin
    #1;
    if (chk_en && sda_t !== prev_sda_t) begin
      check("hold_dly", cyc - fall_cyc, LAT + HOLD_CYC);
      check("chg_scl_hi", scl_in, 1'b0);
    end
    prev_sda_t = sda_t;
    if (!sda_t) low_cnt++;
    if (glitch_win && busy) glitch_seen = 1'b1;
    if (wr_pulse) begin
      if (exp_q.size() == 0) check("wr_unexp", 1'b1, 1'b0);
      else check("wr_commit", {wr_addr, wr_data}, exp_q.pop_front());
    end
  end

  // Driver tasks
  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    ticks(Q); ctrl_sda = 1'b1;
    ticks(Q); ctrl_scl = 1'b1;
    ticks(Q); ctrl_sda = 1'b0;
    ticks(Q); ctrl_scl = 1'b0; fall_cyc = cyc;
  endtask

  task automatic bus_stop();
    ticks(Q); ctrl_sda = 1'b0;
    ticks(Q); ctrl_scl = 1'b1;
    ticks(Q); ctrl_sda = 1'b1;
    ticks(2 * Q);
  endtask

  task automatic xfer_bit(input logic b, output logic r);
    ticks(Q); ctrl_sda = b;
    ticks(Q); ctrl_scl = 1'b1;
    ticks(Q); r = sda_in;
    ticks(Q); ctrl_scl = 1'b0; fall_cyc = cyc;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) xfer_bit(b[i], r);
    xfer_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(1'b1, r);
      d[i] = r;
    end
    xfer_bit(nack, r);
  endtask

  task automatic send_ack(input string tag, input logic [7:0] b, input logic exp_ack);
    logic ack;
    write_byte(b, ack);
    check(tag, ack, exp_ack);
  endtask

  task automatic send_data(input string tag, input logic [3:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
    model[a] = d;
    send_ack(tag, d, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic r;
    for (int i = 0; i < NREGS; i++) model[i] = 8'h00;

    // Reset values
    ticks(3);
    check("rst_sda_t", sda_t, 1'b1);
    check("rst_scl_t", scl_t, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_regs", regs_flat, '0);
    check("rst_wr", {wr_pulse, wr_addr, wr_data}, '0);
    rst_n = 1'b1;
    ticks(5);
    chk_en = 1'b1;

    // Write two bytes from pointer 2
    bus_start();
    send_ack("w_addr_ack", 8'h7C, 1'b0);
    send_ack("w_ptr_ack", 8'h02, 1'b0);
    send_data("w_d0_ack", 4'd2, 8'hA5);
    send_data("w_d1_ack", 4'd3, 8'h5A);
    bus_stop();
    check("w_reg2", regs_flat[2*8 +: 8], 8'hA5);
    check("w_reg3", regs_flat[3*8 +: 8], 8'h5A);
    check("w_busy", busy, 1'b0);

    // Pointer write, repeated START, read two bytes (ACK then NACK)
    bus_start();
    send_ack("r_addr_ack", 8'h7C, 1'b0);
    send_ack("r_ptr_ack", 8'h02, 1'b0);
    bus_start();
    send_ack("r_raddr_ack", 8'h7D, 1'b0);
    read_byte(1'b0, d);
    check("r_byte0", d, model[2]);
    read_byte(1'b1, d);
    check("r_byte1", d, model[3]);
    ticks(Q);
    check("r_nack_rel", sda_t, 1'b1);
    check("r_ptr", dut.ptr, 4'd4);
    bus_stop();
    check("r_busy", busy, 1'b0);

    // Address mismatch: never pulls SDA low
    low_cnt = 0;
    bus_start();
    send_ack("mis_nack", 8'hE0, 1'b1);
    bus_stop();
    check("mis_low", low_cnt, 0);
    check("mis_busy", busy, 1'b0);

    // Pointer wrap
    bus_start();
    send_ack("wrap_addr", 8'h7C, 1'b0);
    send_ack("wrap_ptr", 8'h0F, 1'b0);
    send_data("wrap_d0", 4'd15, 8'h11);
    send_data("wrap_d1", 4'd0, 8'h22);
    bus_stop();
    check("wrap_reg15", regs_flat[15*8 +: 8], 8'h11);
    check("wrap_reg0", regs_flat[0 +: 8], 8'h22);

    // Pointer byte is taken modulo NREGS
    bus_start();
    send_ack("mod_addr", 8'h7C, 1'b0);
    send_ack("mod_ptr", 8'h13, 1'b0);
    send_data("mod_d0", 4'd3, 8'h33);
    bus_stop();
    check("mod_reg3", regs_flat[3*8 +: 8], 8'h33);

    // STOP after 5 data bits: nothing committed
    bus_start();
    send_ack("ab_addr", 8'h7C, 1'b0);
    send_ack("ab_ptr", 8'h05, 1'b0);
    for (int i = 0; i < 5; i++) xfer_bit(1'b1, r);
    bus_stop();
    check("ab_regs", regs_flat, model_flat());
    check("ab_sda_t", sda_t, 1'b1);
    check("ab_busy", busy, 1'b0);

    // Reset pulse while the address ACK is being driven
    bus_start();
    for (int i = 7; i >= 0; i--) xfer_bit(d7c(i), r);
    ticks(Q);
    check("rs_ack_drv", sda_t, 1'b0);
    chk_en = 1'b0;
    rst_n = 1'b0;
    ticks(1);
    rst_n = 1'b1;
    for (int i = 0; i < NREGS; i++) model[i] = 8'h00;
    check("rs_sda_t", sda_t, 1'b1);
    check("rs_regs", regs_flat, model_flat());
    check("rs_busy", busy, 1'b0);
    ctrl_sda = 1'b1;
    ticks(Q);
    ctrl_scl = 1'b1;
    ticks(2 * Q);
    chk_en = 1'b1;

`ifdef I2C_TARGET_GLITCH_FILT_EN
    // One-clock SDA pulse with SCL high must not look like START/STOP
    glitch_seen = 1'b0;
    glitch_win = 1'b1;
    ctrl_sda = 1'b0;
    ticks(1);
    ctrl_sda = 1'b1;
    ticks(20);
    glitch_win = 1'b0;
    check("glitch", glitch_seen, 1'b0);
`endif

    ticks(5);
    check("wr_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  function automatic logic d7c(input int i);
    logic [7:0] v;
    v = 8'h7C;
    return v[i];
  endfunction

endmodule
